// File: rtl/fft_bfly_addsub.sv
// Pipelined complex radix-2 butterfly: sum = a+b, dif = a-b, two register stages, valid/ready.
// Optional BFLY_SATURATE_EN clamps overflowing unscaled components instead of wrapping.
module fft_bfly_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_scale,
   input  logic signed [WIDTH-1:0] a_re,
   input  logic signed [WIDTH-1:0] a_im,
   input  logic signed [WIDTH-1:0] b_re,
   input  logic signed [WIDTH-1:0] b_im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] sum_re,
   output logic signed [WIDTH-1:0] sum_im,
   output logic signed [WIDTH-1:0] dif_re,
   output logic signed [WIDTH-1:0] dif_im,
   output logic                    ovf,
   input  logic                    ovf_clr,
   output logic [CNT_W-1:0]        out_count
);

   // Returns {overflow, result} for one component.
   function automatic logic [WIDTH:0] addsub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sub,
                                             input logic             scale);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] res;
      logic             ov;
      full = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
                 : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
      ov   = 1'b0;
      if (scale) begin
         res = full[WIDTH:1];
      end else begin
         res = full[WIDTH-1:0];
         ov  = full[WIDTH] ^ full[WIDTH-1];
`ifdef BFLY_SATURATE_EN
         if (ov) begin
            res = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         end
`endif
      end
      return {ov, res};
   endfunction

   logic             r_s1_valid;
   logic             r_s1_scale;
   logic [WIDTH-1:0] r_s1_a_re, r_s1_a_im, r_s1_b_re, r_s1_b_im;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_sum_re, r_sum_im, r_dif_re, r_dif_im;
   logic             r_ovf;
   logic [CNT_W-1:0] r_count;

   logic             w_s1_ready, w_s2_ready;
   logic [WIDTH-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;
   logic             w_ov_sr, w_ov_si, w_ov_dr, w_ov_di, w_any_ovf;

   assign w_s2_ready = !r_s2_valid || out_ready;
   assign w_s1_ready = !r_s1_valid || w_s2_ready;
   assign in_ready   = w_s1_ready;

   assign {w_ov_sr, w_sum_re} = addsub(r_s1_a_re, r_s1_b_re, 1'b0, r_s1_scale);
   assign {w_ov_si, w_sum_im} = addsub(r_s1_a_im, r_s1_b_im, 1'b0, r_s1_scale);
   assign {w_ov_dr, w_dif_re} = addsub(r_s1_a_re, r_s1_b_re, 1'b1, r_s1_scale);
   assign {w_ov_di, w_dif_im} = addsub(r_s1_a_im, r_s1_b_im, 1'b1, r_s1_scale);
   assign w_any_ovf = w_ov_sr | w_ov_si | w_ov_dr | w_ov_di;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_scale <= 1'b0;
         r_s1_a_re  <= '0;
         r_s1_a_im  <= '0;
         r_s1_b_re  <= '0;
         r_s1_b_im  <= '0;
         r_s2_valid <= 1'b0;
         r_sum_re   <= '0;
         r_sum_im   <= '0;
         r_dif_re   <= '0;
         r_dif_im   <= '0;
         r_ovf      <= 1'b0;
         r_count    <= '0;
      end else begin
         // S1: operand capture
         if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_scale <= in_scale;
               r_s1_a_re  <= a_re;
               r_s1_a_im  <= a_im;
               r_s1_b_re  <= b_re;
               r_s1_b_im  <= b_im;
            end
         end
         // S2: result capture
         if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_sum_re <= w_sum_re;
               r_sum_im <= w_sum_im;
               r_dif_re <= w_dif_re;
               r_dif_im <= w_dif_im;
            end
         end
         // Set has priority over clear
         if (w_s2_ready && r_s1_valid && w_any_ovf) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
         if (r_s2_valid && out_ready) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign sum_re    = r_sum_re;
   assign sum_im    = r_sum_im;
   assign dif_re    = r_dif_re;
   assign dif_im    = r_dif_im;
   assign ovf       = r_ovf;
   assign out_count = r_count;

endmodule

// File: tb/tb_fft_bfly_addsub.sv
// Scoreboard bench for fft_bfly_addsub (WIDTH=8, CNT_W=4): directed corner cases plus random traffic.
module tb_fft_bfly_addsub;
   localparam int unsigned W  = 8;
   localparam int unsigned CW = 4;
   localparam int MAXV = 127;
   localparam int MINV = -128;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid, in_ready, in_scale;
   logic signed [W-1:0] a_re, a_im, b_re, b_im;
   logic                out_valid, out_ready;
   logic signed [W-1:0] sum_re, sum_im, dif_re, dif_im;
   logic                ovf, ovf_clr;
   logic [CW-1:0]       out_count;

   fft_bfly_addsub #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_scale(in_scale),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_re(sum_re), .sum_im(sum_im), .dif_re(dif_re), .dif_im(dif_im),
      .ovf(ovf), .ovf_clr(ovf_clr), .out_count(out_count)
   );

   always #5 clk = ~clk;

   typedef struct { int sr; int si; int dr; int di; bit ov; } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   m_count = 0;
   bit   m_sticky = 1'b0;
   bit   chk_ovf = 1'b1;
   bit   rnd_done = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Mathematical reference: exact sum, floor halving, or wrap/clamp to the signed range.
   function automatic int ref_op(input int a, input int b, input bit sub, input bit sc, output bit ov);
      int s;
      s  = sub ? a - b : a + b;
      ov = 1'b0;
      if (sc) return (s >= 0) ? s / 2 : -((1 - s) / 2);
      if (s > MAXV) begin
         ov = 1'b1;
`ifdef BFLY_SATURATE_EN
         return MAXV;
`else
         return s - 256;
`endif
      end
      if (s < MINV) begin
         ov = 1'b1;
`ifdef BFLY_SATURATE_EN
         return MINV;
`else
         return s + 256;
`endif
      end
      return s;
   endfunction

   function automatic exp_t model(input bit sc, input int ar, input int ai, input int br, input int bi);
      exp_t e;
      bit o1, o2, o3, o4;
      e.sr = ref_op(ar, br, 1'b0, sc, o1);
      e.si = ref_op(ai, bi, 1'b0, sc, o2);
      e.dr = ref_op(ar, br, 1'b1, sc, o3);
      e.di = ref_op(ai, bi, 1'b1, sc, o4);
      e.ov = o1 | o2 | o3 | o4;
      return e;
   endfunction

   function automatic int rnd_val();
      case ($urandom_range(0, 7))
         0:       return MINV;
         1:       return MAXV;
         2:       return 0;
         default: return int'($urandom_range(0, 255)) - 128;
      endcase
   endfunction

   // Present one beat and hold it until accepted; expectation is queued at acceptance.
   task automatic send(input bit sc, input int ar, input int ai, input int br, input int bi);
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_scale = sc;
      a_re = W'(ar); a_im = W'(ai); b_re = W'(br); b_im = W'(bi);
      #1;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!in_ready) chk("send_timeout_in_ready", int'(in_ready), 1);
      else q.push_back(model(sc, ar, ai, br, bi));
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Assert reset at the current point (async), check reset values, release at next negedge.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      in_valid = 1'b0;
      ovf_clr = 1'b0;
      out_ready = 1'b1;
      q.delete();
      m_count = 0;
      m_sticky = 1'b0;
      #1;
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_ovf"}, int'(ovf), 0);
      chk({tag, "_out_count"}, int'(out_count), 0);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      chk({tag, "_sum_re"}, int'(sum_re), 0);
      chk({tag, "_dif_im"}, int'(dif_im), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Single beat into an empty pipe: out_valid must appear exactly two edges after acceptance.
   task automatic lat_check(input string tag, input bit sc, input int ar, input int ai,
                            input int br, input int bi);
      send(sc, ar, ai, br, bi);
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      chk({tag, "_lat1_out_valid"}, int'(out_valid), 0);
      @(negedge clk);
      #3;
      chk({tag, "_lat2_out_valid"}, int'(out_valid), 1);
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (q.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_drain_left"}, q.size(), 0);
   endtask

   // Monitor: compares every presented output beat against the head of the scoreboard.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         chk("out_count", int'(out_count), m_count);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", int'(out_valid), 0);
            end else begin
               mon_e = q[0];
               chk("sum_re", int'(sum_re), mon_e.sr);
               chk("sum_im", int'(sum_im), mon_e.si);
               chk("dif_re", int'(dif_re), mon_e.dr);
               chk("dif_im", int'(dif_im), mon_e.di);
               if (chk_ovf) chk("ovf", int'(ovf), int'(m_sticky | mon_e.ov));
               if (out_ready) begin
                  void'(q.pop_front());
                  m_count = (m_count + 1) % (1 << CW);
                  m_sticky = m_sticky | mon_e.ov;
               end
            end
         end else if (chk_ovf) begin
            chk("ovf_idle", int'(ovf), int'(m_sticky));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0;
      rst = 1'b1;
      in_valid = 1'b0; in_scale = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0;
      @(negedge clk);
      do_reset("rst0");

      // Unscaled positive overflow
      lat_check("t1", 1'b0, 100, 0, 50, 0);
`ifdef BFLY_SATURATE_EN
      chk("t1_sum_re", int'(sum_re), 127);
`else
      chk("t1_sum_re", int'(sum_re), -106);
`endif
      chk("t1_dif_re", int'(dif_re), 50);
      chk("t1_ovf", int'(ovf), 1);
      @(negedge clk);
      #3;
      chk("t1_out_count", int'(out_count), 1);

      // Scaled: no overflow from reset
      @(negedge clk);
      do_reset("rst1");
      lat_check("t2", 1'b1, 100, 0, 50, 0);
      chk("t2_sum_re", int'(sum_re), 75);
      chk("t2_dif_re", int'(dif_re), 25);
      chk("t2_ovf", int'(ovf), 0);

      // Negative overflow on imaginary difference, then clear and set/clear collision
      lat_check("t3", 1'b0, 0, -128, 0, 1);
`ifdef BFLY_SATURATE_EN
      chk("t3_dif_im", int'(dif_im), -128);
`else
      chk("t3_dif_im", int'(dif_im), 127);
`endif
      chk("t3_ovf", int'(ovf), 1);
      @(negedge clk);
      @(negedge clk);
      chk_ovf = 1'b0;
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #3;
      chk("t3_ovf_cleared", int'(ovf), 0);
      m_sticky = 1'b0;
      send(1'b0, 0, -128, 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #3;
      chk("t3_set_beats_clr", int'(ovf), 1);
      drain("t3");
      m_sticky = 1'b1;
      chk_ovf = 1'b1;

      // Backpressure: five beats, output stalled for four cycles
      @(negedge clk);
      cnt0 = m_count;
      fork
         begin
            for (int k = 0; k < 5; k++) send(k[0], 10 * k, -5 * k, 3, k);
            idle();
         end
         begin
            @(negedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            @(negedge clk);
            #1;
            chk("stall_in_ready", int'(in_ready), 0);
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain("stall");
      @(negedge clk);
      #3;
      chk("stall_out_count", int'(out_count), (cnt0 + 5) % (1 << CW));

      // Floor rounding of a negative odd value
      lat_check("t5", 1'b1, -3, 0, 0, 0);
      chk("t5_sum_re", int'(sum_re), -2);
      chk("t5_dif_re", int'(dif_re), -2);
      drain("t5");

      // Reset with two beats in flight
      send(1'b0, 1, 2, 3, 4);
      send(1'b0, 5, 6, 7, 8);
      @(negedge clk);
      do_reset("rst_mid");
      lat_check("t6", 1'b0, -20, 30, 40, -50);
      drain("t6");

      // Random traffic with random backpressure (counter wraps several times)
      @(negedge clk);
      do_reset("rst_rnd");
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               if ($urandom_range(0, 3) == 0) idle();
               send(1'($urandom_range(0, 1)), rnd_val(), rnd_val(), rnd_val(), rnd_val());
            end
            idle();
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain("rnd");
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
